// File: rtl/udp_vec_gen_if.sv
// udp_vec_gen_if: stimulus/response bundle between vector generator and UDP stage.
// master drives a/b/sel and reads y/q_latch/q_trig; slave is the UDP stage side.
interface udp_vec_gen_if;
  logic a;
  logic b;
  logic sel;
  logic y;
  logic q_latch;
  logic q_trig;

  modport master (
    output a, b, sel,
    input  y, q_latch, q_trig
  );

  modport slave (
    input  a, b, sel,
    output y, q_latch, q_trig
  );
endinterface

// File: rtl/udp_vec_gen.sv
// udp_vec_gen: sweeps {a,b,sel} over 0..7, checks mux/latch/flop against a golden model.
// Ports: clk, rst_n, start; vec (master: a,b,sel out / y,q_latch,q_trig in);
// busy, done, err_cnt (saturating), pass.
// Macro UDP_VEC_GEN_FAILCAP_EN adds fail_idx/fail_mask (first failing vector).
module udp_vec_gen #(
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  udp_vec_gen_if.master    vec,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
`ifdef UDP_VEC_GEN_FAILCAP_EN
  output logic [2:0]       fail_idx,
  output logic [2:0]       fail_mask,
`endif
  output logic             pass
);

  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       vec_q, vec_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             mreg_q, mreg_d;
  logic             lv_q, lv_d;

`ifdef UDP_VEC_GEN_FAILCAP_EN
  logic [2:0]       fidx_q, fidx_d;
  logic [2:0]       fmask_q, fmask_d;
`endif

  logic va, vb, vs;
  logic cmp;
  logic exp_y, exp_l;
  logic mis_y, mis_l, mis_t;
  logic fail;

  assign {va, vb, vs} = vec_q;
  assign cmp   = (state_q == DRIVE) && (hold_q == HLAST);
  assign exp_y = vs ? vb : va;
  assign exp_l = vs ? va : mreg_q;
  // Case inequality so X/Z responses count as mismatches in simulation.
  assign mis_y = (vec.y !== exp_y);
  assign mis_l = (lv_q | vs) & (vec.q_latch !== exp_l);
  assign mis_t = (vec.q_trig !== va);
  assign fail  = mis_y | mis_l | mis_t;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    mreg_d  = mreg_q;
    lv_d    = lv_q;
`ifdef UDP_VEC_GEN_FAILCAP_EN
    fidx_d  = fidx_q;
    fmask_d = fmask_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          hold_d  = '0;
          err_d   = '0;
          lv_d    = 1'b0;
`ifdef UDP_VEC_GEN_FAILCAP_EN
          fidx_d  = 3'd0;
          fmask_d = 3'd0;
`endif
        end
      end
      DRIVE: begin
        if (cmp) begin
          hold_d = '0;
          if (fail && (err_q != '1))
            err_d = err_q + ERR_W'(1);
          if (vs) begin
            mreg_d = va;
            lv_d   = 1'b1;
          end
`ifdef UDP_VEC_GEN_FAILCAP_EN
          if (fail && (fmask_q == 3'd0)) begin
            fidx_d  = idx_q;
            fmask_d = {mis_y, mis_l, mis_t};
          end
`endif
          if (idx_q == 3'd7)
            state_d = DONE;
          else
            idx_d = idx_q + 3'd1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    vec_d = (state_d == DRIVE) ? idx_d : 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      vec_q   <= 3'd0;
      hold_q  <= '0;
      err_q   <= '0;
      mreg_q  <= 1'b0;
      lv_q    <= 1'b0;
`ifdef UDP_VEC_GEN_FAILCAP_EN
      fidx_q  <= 3'd0;
      fmask_q <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      mreg_q  <= mreg_d;
      lv_q    <= lv_d;
`ifdef UDP_VEC_GEN_FAILCAP_EN
      fidx_q  <= fidx_d;
      fmask_q <= fmask_d;
`endif
    end
  end

  assign vec.a   = va;
  assign vec.b   = vb;
  assign vec.sel = vs;
  assign busy    = (state_q == DRIVE);
  assign done    = (state_q == DONE);
  assign err_cnt = err_q;
  assign pass    = done && (err_q == '0);
`ifdef UDP_VEC_GEN_FAILCAP_EN
  assign fail_idx  = fidx_q;
  assign fail_mask = fmask_q;
`endif

endmodule

// File: tb/tb_udp_vec_gen.sv
// tb_udp_vec_gen: two generators (HOLD 2/ERR_W 8 and HOLD 3/ERR_W 2) driving
// fault-injectable mux/latch/flop models, checked against a per-sweep reference.
module tb_udp_vec_gen;
  localparam int H0 = 2;
  localparam int H1 = 3;
  localparam int W0 = 8;
  localparam int W1 = 2;

  logic clk;
  logic rst_n;
  logic start;
  int   fmode;
  bit   chk_en;
  int   n_chk;
  int   n_fail;
  int   n_print;

  logic [1:0]  bsy, dn, ps;
  logic [7:0]  err0;
  logic [1:0]  err1;
  logic [2:0]  fi0, fm0, fi1, fm1;
  logic        lat0, lat1, trg0, trg1;

  udp_vec_gen_if if0 ();
  udp_vec_gen_if if1 ();

  udp_vec_gen #(.HOLD_CYCLES(H0), .ERR_W(W0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(if0),
    .busy(bsy[0]), .done(dn[0]), .err_cnt(err0),
`ifdef UDP_VEC_GEN_FAILCAP_EN
    .fail_idx(fi0), .fail_mask(fm0),
`endif
    .pass(ps[0])
  );

  udp_vec_gen #(.HOLD_CYCLES(H1), .ERR_W(W1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(if1),
    .busy(bsy[1]), .done(dn[1]), .err_cnt(err1),
`ifdef UDP_VEC_GEN_FAILCAP_EN
    .fail_idx(fi1), .fail_mask(fm1),
`endif
    .pass(ps[1])
  );

`ifndef UDP_VEC_GEN_FAILCAP_EN
  assign fi0 = 3'd0;
  assign fm0 = 3'd0;
  assign fi1 = 3'd0;
  assign fm1 = 3'd0;
`endif

  // Downstream primitives; fmode 1 inverts mux select, 2 sticks latch at 0,
  // 3 ties the flop output high.
  always_latch if (if0.sel) lat0 = if0.a;
  always_latch if (if1.sel) lat1 = if1.a;
  always_ff @(posedge clk) trg0 <= if0.a;
  always_ff @(posedge clk) trg1 <= if1.a;

  assign if0.y = (fmode == 1) ? (if0.sel ? if0.a : if0.b)
                              : (if0.sel ? if0.b : if0.a);
  assign if1.y = (fmode == 1) ? (if1.sel ? if1.a : if1.b)
                              : (if1.sel ? if1.b : if1.a);
  assign if0.q_latch = (fmode == 2) ? 1'b0 : lat0;
  assign if1.q_latch = (fmode == 2) ? 1'b0 : lat1;
  assign if0.q_trig  = (fmode == 3) ? 1'b1 : trg0;
  assign if1.q_trig  = (fmode == 3) ? 1'b1 : trg1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-vector {y,latch,trig} mismatch bits for one sweep under a fault mode.
  function automatic logic [7:0][2:0] sweep_masks(input int mode);
    logic [7:0][2:0] r;
    logic [2:0] v;
    logic a, b, s, y, ql, qt, lat, lv;
    r = '0;
    lat = 1'b0;
    lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a = v[2];
      b = v[1];
      s = v[0];
      if (s) begin
        lat = a;
        lv = 1'b1;
      end
      y  = (mode == 1) ? (s ? a : b) : (s ? b : a);
      ql = (mode == 2) ? 1'b0 : lat;
      qt = (mode == 3) ? 1'b1 : a;
      r[i] = {y != (s ? b : a), lv && (ql != lat), qt != a};
    end
    return r;
  endfunction

  function automatic int satc(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic int hold_of(input int k);
    return (k == 0) ? H0 : H1;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, k, $time, act, exp);
      end
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out @%0t", nm, $time);
  endtask

  // Reference: 0 idle, 1 running, 2 done; m_cyc counts edges since start.
  int              m_st  [2];
  int              m_cyc [2];
  logic [7:0][2:0] m_msk [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k]  <= 0;
        m_cyc[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_st[k] != 1) begin
          if (start) begin
            m_st[k]  <= 1;
            m_cyc[k] <= 0;
            m_msk[k] <= sweep_masks(fmode);
          end
        end else begin
          m_cyc[k] <= m_cyc[k] + 1;
          if (m_cyc[k] + 1 == 8 * hold_of(k))
            m_st[k] <= 2;
        end
      end
    end
  end

  int c_h, c_done, c_nf, c_fi, c_fm, c_err, c_vec;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        c_h = hold_of(k);
        c_done = (m_st[k] == 1) ? m_cyc[k] / c_h : ((m_st[k] == 2) ? 8 : 0);
        c_nf = 0;
        c_fi = 0;
        c_fm = 0;
        for (int i = 0; i < c_done; i++) begin
          if (m_msk[k][i] != 3'd0) begin
            if (c_nf == 0) begin
              c_fi = i;
              c_fm = int'(m_msk[k][i]);
            end
            c_nf++;
          end
        end
        c_err = satc(c_nf, (k == 0) ? W0 : W1);
        chk("busy", k, int'(bsy[k]), int'(m_st[k] == 1));
        chk("done", k, int'(dn[k]), int'(m_st[k] == 2));
        chk("err_cnt", k, (k == 0) ? int'(err0) : int'(err1), c_err);
        chk("pass", k, int'(ps[k]), int'(m_st[k] == 2 && c_err == 0));
        if (m_st[k] == 1) begin
          c_vec = (k == 0) ? int'({if0.a, if0.b, if0.sel})
                           : int'({if1.a, if1.b, if1.sel});
          chk("vector", k, c_vec, m_cyc[k] / c_h);
        end
`ifdef UDP_VEC_GEN_FAILCAP_EN
        chk("fail_idx", k, (k == 0) ? int'(fi0) : int'(fi1), c_fi);
        chk("fail_mask", k, (k == 0) ? int'(fm0) : int'(fm1), c_fm);
`endif
      end
    end
  end

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 0, int'(bsy), 0);
    chk("rst_done", 0, int'(dn), 0);
    chk("rst_pass", 0, int'(ps), 0);
    chk("rst_err", 0, int'(err0), 0);
    chk("rst_err", 1, int'(err1), 0);
    chk("rst_vec", 0, int'({if0.a, if0.b, if0.sel}), 0);
    chk("rst_vec", 1, int'({if1.a, if1.b, if1.sel}), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bsy != 2'b00) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        timeout("wait_idle");
        break;
      end
    end
  endtask

  // xs: cycle in which start is re-pulsed; rs: cycle in which reset hits.
  task automatic run_sweep(input int mode, input int xs, input int rs,
                           output int bcnt);
    int cyc;
    wait_idle();
    @(posedge clk);
    #1;
    fmode = mode;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcnt = 0;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (bsy[0]) bcnt++;
      if (bsy == 2'b00) break;
      if (cyc > 200) begin
        timeout("sweep");
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == xs);
      if (cyc == rs) do_reset();
    end
    start = 1'b0;
  endtask

  int bc;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fmode = 0;
    chk_en = 1'b0;
    n_chk = 0;
    n_fail = 0;
    n_print = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("init_busy", 0, int'(bsy), 0);
    chk("init_done", 0, int'(dn), 0);

    run_sweep(0, -1, -1, bc);
    chk("lit_busy_len", 0, bc, 16);
    chk("lit_err", 0, int'(err0), 0);
    chk("lit_pass", 0, int'(ps[0]), 1);
    chk("lit_pass", 1, int'(ps[1]), 1);

    run_sweep(1, -1, -1, bc);
    chk("lit_err_mux", 0, int'(err0), 4);
    chk("lit_err_mux", 1, int'(err1), 3);
    chk("lit_pass_mux", 0, int'(ps[0]), 0);
`ifdef UDP_VEC_GEN_FAILCAP_EN
    chk("lit_fidx_mux", 0, int'(fi0), 2);
    chk("lit_fmask_mux", 0, int'(fm0), 4);
`endif

    run_sweep(2, -1, -1, bc);
    chk("lit_err_latch", 0, int'(err0), 3);
    chk("lit_err_latch", 1, int'(err1), 3);
`ifdef UDP_VEC_GEN_FAILCAP_EN
    chk("lit_fidx_latch", 0, int'(fi0), 5);
    chk("lit_fmask_latch", 0, int'(fm0), 2);
`endif

    run_sweep(3, -1, -1, bc);
    chk("lit_err_trig", 0, int'(err0), 4);
    chk("lit_err_trig_sat", 1, int'(err1), 3);
`ifdef UDP_VEC_GEN_FAILCAP_EN
    chk("lit_fmask_trig", 0, int'(fm0), 1);
`endif

    run_sweep(0, 5, -1, bc);
    chk("lit_busy_len_restart", 0, bc, 16);
    chk("lit_pass_rerun", 0, int'(ps[0]), 1);

    run_sweep(0, -1, 7, bc);
    repeat (3) @(negedge clk);
    chk("lit_busy_after_rst", 0, int'(bsy), 0);
    run_sweep(0, -1, -1, bc);
    chk("lit_busy_len_after_rst", 0, bc, 16);
    chk("lit_pass_after_rst", 0, int'(ps[0]), 1);

    for (int it = 0; it < 30; it++) begin
      int md, xs, rs;
      md = $urandom_range(0, 3);
      xs = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 30) : -1;
      rs = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 20) : -1;
      run_sweep(md, xs, rs, bc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_vec_gen.md
# udp_vec_gen

Self-checking vector sequencer that sits directly upstream of the UDP application stage and consumes its responses. It drives the shared `a`, `b` and `sel` stimulus into the 2:1 mux, level latch and edge flop primitives, then samples `y`, `q_latch` and `q_trig`. It compares them against an internal golden model and reports a saturating error count with a pass/done flag. This replaces hand-written `#delay` stimulus with a clocked, repeatable sweep of all eight `{a,b,sel}` combinations.

## Interface
- `HOLD_CYCLES`, default 2: clocks each vector is held; legal range ≥2.
- `ERR_W`, default 8: width of the error counter.
- `clk`  in  1  rising-edge clock, shared with the downstream edge-flop primitive.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run one sweep.
- `y`  in  1  mux output from the downstream stage.
- `q_latch`  in  1  latch output from the downstream stage.
- `q_trig`  in  1  edge-flop output from the downstream stage.
- `a`  out  1  stimulus: mux input 0, latch data, flop data.
- `b`  out  1  stimulus: mux input 1.
- `sel`  out  1  stimulus: mux select, latch enable.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep complete; held until the next accepted `start`.
- `err_cnt`  out  ERR_W  number of failing vectors, saturating.
- `pass`  out  1  `done && err_cnt==0`.

## Operation
- FSM states: IDLE, DRIVE, DONE.
  - IDLE: `start`=1 → DRIVE, with idx=0 and `err_cnt` cleared.
  - DRIVE: runs idx 0..7. Vector mapping is `a`=idx[2], `b`=idx[1], `sel`=idx[0]. All three outputs are registered.
  - Hold counter runs 0..HOLD_CYCLES-1 per vector. At count HOLD_CYCLES-1, compare, then advance idx (or go to DONE after idx 7).
  - DONE: `start`=1 → DRIVE, clearing `err_cnt` and `done`.
- `start` while `busy`=1 is ignored.
- Golden model, evaluated on the compare cycle:
  - `exp_y` = `sel` ? `b` : `a`.
  - `exp_trig` = `a`. This holds because the vector has been stable for ≥1 prior rising edge.
  - `exp_latch`: a model register loads `a` whenever `sel`=1 on a compare cycle. The expected value is `a` if `sel`=1, otherwise the model register.
  - Latch check is suppressed until `latch_valid` is set. `latch_valid` is set by the first compare with `sel`=1, and cleared on start and on reset.
- A vector fails if any checked output mismatches. In simulation, X/Z on an input also counts as a mismatch.
- A failing vector increments `err_cnt` by exactly 1. The counter saturates at 2^ERR_W-1 with no wrap.
- Reset values: `a`=`b`=`sel`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, FSM=IDLE, model register=0, `latch_valid`=0.
- Reset asserted mid-sweep aborts immediately to the reset values. No partial `done` is produced.

## Timing
- `start` is sampled at rising edge T. `busy`=1 and vector 0 appear on the outputs after edge T.
- Vector k is on the outputs for exactly HOLD_CYCLES cycles.
- The compare uses the input values present at the final edge of each hold window.
- `done`=1 and `busy`=0 after edge T+8·HOLD_CYCLES. The final `err_cnt` and `pass` are valid in that same cycle.
- `busy` is high for exactly 8·HOLD_CYCLES cycles.
- `start` in DONE: the cycle after the accepting edge shows `done`=0, `busy`=1, `err_cnt`=0.

## Configuration
- `UDP_VEC_GEN_FAILCAP_EN`
  - Defined: adds output ports `fail_idx[2:0]` and `fail_mask[2:0]` ({y,latch,trig} mismatch bits). They capture the first failing vector of a sweep and stay sticky until the next start or reset. Reset value is 0. `fail_mask`=0 means no failure has occurred.
  - Undefined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- Correct mux/latch/flop models, HOLD_CYCLES=2, one `start` pulse → `busy` high 16 cycles, then `done`=1, `err_cnt`=0, `pass`=1.
- Mux with inverted select (`y`=`sel`?`a`:`b`) → `err_cnt`=4 (idx 2,3,4,5), `pass`=0. With FAILCAP, `fail_idx`=2 and `fail_mask`=3'b100.
- `q_latch` stuck at 0 → `err_cnt`=3 (idx 5,6,7). idx 0 is unchecked.
- `q_trig` tied to 1, ERR_W=2 → 4 raw failures (idx 0–3); `err_cnt` saturates at 3.
- `start` pulsed again at cycle 5 of a sweep → ignored; `done` still asserts at cycle 16. A second `start` from DONE reruns and clears the result.
- `rst_n` low at cycle 7 of a sweep → all outputs 0 asynchronously. After release, `busy`=0 until the next `start`; a full sweep then completes normally.
